// File: rtl/scalar_product_mac_stream.sv
// -----------------------------------------------------------------------------
// scalar_product_mac_stream
//
// Streaming dot-product engine. One pair of Ndata-element vectors is accepted
// per transaction over a valid/ready handshake and reduced on Nmac parallel MAC
// lanes. Lane n walks elements n*Nacc .. n*Nacc+Nacc-1 one per cycle, then the
// lane accumulators are summed once. Operands are signed or unsigned per
// transaction. The result is full precision and cannot overflow at the default
// output width.
//
// Transaction timing (acceptance edge E0):
//   E0            IDLE -> MAC, operands latched, accumulators cleared
//   E1..E(Nacc)   one MAC step per edge
//   E(Nacc+1)     SUM -> HOLD, result and out_valid visible
//   handshake     HOLD -> IDLE on an edge with out_ready=1
// With in_valid and out_ready tied high a result appears every Nacc+3 cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   A, B and signed_en are valid
//   in_ready   block can accept a transaction (IDLE only)
//   A, B       packed vectors, element i = X[(i+1)*Nbits-1 : i*Nbits]
//   signed_en  1 = two's-complement operands, 0 = unsigned
//   out_valid  out holds a valid result (HOLD only)
//   out_ready  consumer accepts out
//   out        dot product, two's complement when signed_en was 1
//   busy       high while in MAC or SUM
// -----------------------------------------------------------------------------
module scalar_product_mac_stream #(
  parameter int Nbits = 4,
  parameter int Ndata = 8,
  parameter int Nmac  = 2,
  parameter int Wout  = 2*Nbits + $clog2(Ndata)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Ndata*Nbits-1:0] A,
  input  logic [Ndata*Nbits-1:0] B,
  input  logic                   signed_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Wout-1:0]        out,
  output logic                   busy
);

  localparam int Nacc = Ndata / Nmac;
  localparam int KW   = (Nacc > 1) ? $clog2(Nacc) : 1;
  // Working width for a single product before it is narrowed to Wout; a
  // (Nbits+1)x(Nbits+1) signed product needs 2*Nbits+2 bits.
  localparam int PW   = (Wout > 2*Nbits + 2) ? Wout : 2*Nbits + 2;
  localparam logic [KW-1:0] K_LAST = KW'(Nacc - 1);

  // Illegal configurations stop elaboration.
  if (Ndata % Nmac != 0) begin : g_bad_nmac
    $error("scalar_product_mac_stream: Ndata must be a multiple of Nmac");
  end
  if (Wout < 2*Nbits + $clog2(Ndata)) begin : g_bad_wout
    $error("scalar_product_mac_stream: Wout below the full-precision width");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_SUM  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [Ndata*Nbits-1:0]   a_p0;
  logic [Ndata*Nbits-1:0]   b_p0;
  logic                     sgn_p0;
  logic [KW-1:0]            k;
  logic signed [Wout-1:0]   acc_p1 [Nmac];
  logic signed [Wout-1:0]   sum_c;
  logic [Nbits-1:0]         ea [Nmac];
  logic [Nbits-1:0]         eb [Nmac];
  logic                     k_last;

  // One lane product, extended to the accumulator width. The extra top bit on
  // each operand is the sign in signed mode and zero in unsigned mode, so a
  // single signed multiplier serves both modes.
  function automatic logic signed [Wout-1:0] mac_term(
    input logic [Nbits-1:0] a_el,
    input logic [Nbits-1:0] b_el,
    input logic             sgn
  );
    logic signed [Nbits:0]     ae;
    logic signed [Nbits:0]     be;
    logic signed [2*Nbits+1:0] prod;
    logic signed [PW-1:0]      wide;
    ae   = $signed({sgn & a_el[Nbits-1], a_el});
    be   = $signed({sgn & b_el[Nbits-1], b_el});
    prod = (2*Nbits+2)'(ae) * (2*Nbits+2)'(be);
    wide = PW'(prod);
    return $signed(wide[Wout-1:0]);
  endfunction

  assign k_last = (k == K_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_MAC;
      S_MAC:   if (k_last) state_nxt = S_SUM;
      S_SUM:   state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded straight from the state register
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_HOLD);
    busy      = (state == S_MAC) || (state == S_SUM);
  end

  // Element fetch: lane n reads element n*Nacc + k of the latched operands.
  always_comb begin
    for (int n = 0; n < Nmac; n++) begin
      ea[n] = a_p0[(n*Nacc + int'(k))*Nbits +: Nbits];
      eb[n] = b_p0[(n*Nacc + int'(k))*Nbits +: Nbits];
    end
  end

  // Final reduction of the lane accumulators.
  always_comb begin
    sum_c = '0;
    for (int n = 0; n < Nmac; n++) begin
      sum_c = sum_c + acc_p1[n];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: operand capture on acceptance
  // Stage p1: lane accumulation, one element per lane per MAC cycle
  // Stage p2: lane sum into the output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0   <= '0;
      b_p0   <= '0;
      sgn_p0 <= 1'b0;
      k      <= '0;
      out    <= '0;
      for (int n = 0; n < Nmac; n++) begin
        acc_p1[n] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_p0   <= A;
            b_p0   <= B;
            sgn_p0 <= signed_en;
            k      <= '0;
            for (int n = 0; n < Nmac; n++) begin
              acc_p1[n] <= '0;
            end
          end
        end
        S_MAC: begin
          for (int n = 0; n < Nmac; n++) begin
            acc_p1[n] <= acc_p1[n] + mac_term(ea[n], eb[n], sgn_p0);
          end
          // Park k at zero after the last step so it never indexes past the
          // end of a lane when Nacc is not a power of two.
          k <= k_last ? '0 : k + KW'(1);
        end
        S_SUM: begin
          out <= sum_c;
        end
        default: begin
          // HOLD: out stays put until the consumer takes it.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_product_mac_stream.sv
// -----------------------------------------------------------------------------
// Testbench for scalar_product_mac_stream. Three instances (Nmac = 2, 8, 1)
// share clock and reset; the Nmac=2 instance carries the main scenarios and
// all three are driven back-to-back at the end. Expected results come from a
// direct element-by-element dot-product model and go through a queue that the
// output monitor drains on each out_valid/out_ready handshake.
// -----------------------------------------------------------------------------
module tb_scalar_product_mac_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iv   [3];
  logic        ir   [3];
  logic        sg   [3];
  logic        ov   [3];
  logic        orr  [3];
  logic        bsy  [3];
  logic [31:0] av   [3];
  logic [31:0] bv   [3];
  logic [10:0] outv [3];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          sel     = 0;
  bit          gap_chk = 1'b0;
  int          last_hs = -1;
  int          gap_exp [3] = '{7, 4, 11};
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scalar_product_mac_stream #(.Nbits(4), .Ndata(8), .Nmac(2)) dut_m2 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(av[0]), .B(bv[0]), .signed_en(sg[0]), .out_valid(ov[0]),
    .out_ready(orr[0]), .out(outv[0]), .busy(bsy[0]));

  scalar_product_mac_stream #(.Nbits(4), .Ndata(8), .Nmac(8)) dut_m8 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(av[1]), .B(bv[1]), .signed_en(sg[1]), .out_valid(ov[1]),
    .out_ready(orr[1]), .out(outv[1]), .busy(bsy[1]));

  scalar_product_mac_stream #(.Nbits(4), .Ndata(8), .Nmac(1)) dut_m1 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(av[2]), .B(bv[2]), .signed_en(sg[2]), .out_valid(ov[2]),
    .out_ready(orr[2]), .out(outv[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Reference dot product, element by element, independent of lane layout.
  function automatic logic [10:0] dot(input logic [31:0] a, input logic [31:0] b, input logic s);
    int acc = 0;
    for (int i = 0; i < 8; i++) begin
      int ea = int'(a[i*4 +: 4]);
      int eb = int'(b[i*4 +: 4]);
      if (s && ea >= 8) ea -= 16;
      if (s && eb >= 8) eb -= 16;
      acc += ea * eb;
    end
    return 11'(acc);
  endfunction

  // Output monitor: one comparison per handshake, plus spacing in b2b runs.
  always @(negedge clk) begin
    if (!gap_chk) last_hs <= -1;
    if (ov[sel] && orr[sel]) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(ov[sel]), 32'd0);
      else chk("out", 32'(outv[sel]), 32'(exp_q.pop_front()));
      if (gap_chk) begin
        if (last_hs >= 0) chk("gap", cyc - last_hs, gap_exp[sel]);
        last_hs <= cyc;
      end
    end
  end

  // Present a vector and wait for the accepting edge; returns #1 after it.
  task automatic accept(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input bit push, output bit ok);
    @(negedge clk);
    av[i] = a; bv[i] = b; sg[i] = s; iv[i] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (ir[i]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'(ir[i]), 32'd1);
      iv[i] = 1'b0;
      return;
    end
    if (push) exp_q.push_back(dot(a, b, s));
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  // Full transaction with latency check; the monitor checks the value.
  task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int lat);
    bit ok;
    int n;
    sel = i;
    orr[i] = 1'b1;
    accept(i, a, b, s, 1'b1, ok);
    if (!ok) return;
    n = 0;
    while (!ov[i] && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, lat);
    @(posedge clk); #1;
    chk("idle_after", 32'(ir[i]), 32'd1);
  endtask

  // Four vectors with in_valid and out_ready held high.
  logic [31:0] va [4] = '{32'h12345678, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'hA5A5A5A5};
  logic [31:0] vb [4] = '{32'h9ABCDEF0, 32'h01234567, 32'h80808080, 32'h5A5A5A5A};
  logic        vs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  task automatic b2b(input int i);
    bit ok;
    sel = i;
    orr[i] = 1'b1;
    gap_chk = 1'b1;
    for (int v = 0; v < 4; v++) begin
      av[i] = va[v]; bv[i] = vb[v]; sg[i] = vs[v]; iv[i] = 1'b1;
      exp_q.push_back(dot(va[v], vb[v], vs[v]));
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (ir[i]) begin ok = 1'b1; break; end
      end
      if (!ok) chk("b2b_accept_timeout", 32'(ir[i]), 32'd1);
      @(posedge clk); #1;
    end
    iv[i] = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("b2b_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    gap_chk = 1'b0;
    @(posedge clk); #1;
    orr[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; sg[i] = 1'b0; orr[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_out", 32'(outv[0]), 32'd0);
    chk("rst_ov", 32'(ov[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_ir", 32'(ir[0]), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Latency and status flags: all ones, unsigned -> 8
    sel = 0;
    orr[0] = 1'b1;
    accept(0, 32'h11111111, 32'h11111111, 1'b0, 1'b1, ok);
    for (int e = 1; e <= 5; e++) begin
      chk("lat_ir", 32'(ir[0]), 32'd0);
      chk("lat_busy", 32'(bsy[0]), 32'd1);
      chk("lat_ov", 32'(ov[0]), 32'd0);
      @(posedge clk); #1;
    end
    chk("lat_ov_rise", 32'(ov[0]), 32'd1);
    chk("lat_busy_hold", 32'(bsy[0]), 32'd0);
    @(posedge clk); #1;

    // Value patterns
    run_one(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5);   // 1800
    run_one(0, 32'h87654321, 32'h11111111, 1'b0, 5);   // 36
    run_one(0, 32'h88888888, 32'h88888888, 1'b1, 5);   // 512
    run_one(0, 32'h88888888, 32'h77777777, 1'b1, 5);   // -448 = 0x640
    run_one(0, 32'h88888888, 32'h77777777, 1'b0, 5);   // 448

    // Backpressure: result 48 held while a new vector (40) waits
    orr[0] = 1'b0;
    accept(0, 32'h33333333, 32'h22222222, 1'b0, 1'b1, ok);
    n = 0;
    while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 5);
    av[0] = 32'h55555555; bv[0] = 32'h11111111; sg[0] = 1'b0; iv[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_ov", 32'(ov[0]), 32'd1);
      chk("bp_out", 32'(outv[0]), 32'd48);
      chk("bp_ir", 32'(ir[0]), 32'd0);
      @(posedge clk); #1;
    end
    exp_q.push_back(dot(32'h55555555, 32'h11111111, 1'b0));
    orr[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ir", 32'(ir[0]), 32'd1);
    chk("bp_release_ov", 32'(ov[0]), 32'd0);
    chk("bp_out_kept", 32'(outv[0]), 32'd48);
    @(posedge clk); #1;
    chk("bp_accept_ir", 32'(ir[0]), 32'd0);
    chk("bp_accept_busy", 32'(bsy[0]), 32'd1);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp_latency2", n, 5);
    @(posedge clk); #1;

    // Reset during the second MAC cycle aborts the transaction
    accept(0, 32'h11111111, 32'h11111111, 1'b0, 1'b0, ok);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_out", 32'(outv[0]), 32'd0);
    chk("abort_ov", 32'(ov[0]), 32'd0);
    chk("abort_ir", 32'(ir[0]), 32'd1);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    @(negedge clk) reset = 1'b0;
    run_one(0, 32'h22222222, 32'h22222222, 1'b0, 5);   // 32

    // Latency on the other lane counts
    run_one(1, 32'h87654321, 32'hFEDCBA98, 1'b1, 2);
    run_one(2, 32'h87654321, 32'hFEDCBA98, 1'b0, 9);

    // Back-to-back spacing: Nacc+3 for each lane count
    b2b(0);
    b2b(1);
    b2b(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
